// File: rtl/mmc1_cpu_write_front_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mmc1_cpu_write_front_if
// Brief    : Raw Famicom CPU bus inputs and MMC1 register-write strobe outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface mmc1_cpu_write_front_if;
  logic       cpu_m2;
  logic       ncpu_romsel;
  logic       ncpu_rw;
  logic       cpu_a14;
  logic       cpu_a13;
  logic       cpu_d7;
  logic       cpu_d0;
  logic       reg_we;
  logic [1:0] reg_sel;
  logic [4:0] reg_data;
  logic       reset_req;
  logic       wr_ignored;
  logic [2:0] shift_cnt;

  modport master (
    output cpu_m2, ncpu_romsel, ncpu_rw, cpu_a14, cpu_a13, cpu_d7, cpu_d0,
    input  reg_we, reg_sel, reg_data, reset_req, wr_ignored, shift_cnt
  );

  modport slave (
    input  cpu_m2, ncpu_romsel, ncpu_rw, cpu_a14, cpu_a13, cpu_d7, cpu_d0,
    output reg_we, reg_sel, reg_data, reset_req, wr_ignored, shift_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mmc1_cpu_write_front.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mmc1_cpu_write_front
// Brief    : Synchronises the CPU bus, detects $8000-$FFFF writes, applies the
//            consecutive-write filter and assembles the MMC1 5-bit serial load.
// Revision : 1.0 - initial release
// ============================================================================
module mmc1_cpu_write_front #(
  parameter int SYNC_STAGES   = 2,
  parameter int M2_MIN_HIGH   = 3,
  parameter int IGNORE_CONSEC = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  mmc1_cpu_write_front_if.slave  bus
);

  localparam int c_HCNT_W = (M2_MIN_HIGH < 2) ? 1 : $clog2(M2_MIN_HIGH + 1);
  localparam logic [c_HCNT_W-1:0] c_HCNT_SAT = c_HCNT_W'(M2_MIN_HIGH);
  localparam bit c_IGNORE = (IGNORE_CONSEC != 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HIGH   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Synchroniser bundle: {m2, nromsel, nrw, a14, a13, d7, d0}
  logic [6:0] w_raw;
  logic [6:0] r_sync [SYNC_STAGES];
  logic [6:0] w_sync;
  logic       w_m2;
  logic [5:0] w_bus;

  assign w_raw = {bus.cpu_m2, bus.ncpu_romsel, bus.ncpu_rw,
                  bus.cpu_a14, bus.cpu_a13, bus.cpu_d7, bus.cpu_d0};

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_sync[gi] <= '0;
          else     r_sync[gi] <= w_raw;
        end
      end else begin : g_next
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_sync[gi] <= '0;
          else     r_sync[gi] <= r_sync[gi-1];
        end
      end
    end
  endgenerate

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_m2   = w_sync[6];
  assign w_bus  = w_sync[5:0];

  state_t              r_state;
  logic [c_HCNT_W-1:0] r_hcnt;
  logic [5:0]          r_snap;      // {nromsel, nrw, a14, a13, d7, d0}
  logic [4:0]          r_shreg;
  logic [2:0]          r_shift_cnt;
  logic                r_cflag;
  logic                r_reg_we;
  logic                r_reset_req;
  logic                r_wr_ignored;
  logic [1:0]          r_reg_sel;
  logic [4:0]          r_reg_data;

  logic       w_mapper_wr;
  logic [4:0] w_shift_next;

  assign w_mapper_wr  = ~r_snap[5] & ~r_snap[4];
  assign w_shift_next = {r_snap[0], r_shreg[4:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_hcnt       <= '0;
      r_snap       <= '0;
      r_shreg      <= '0;
      r_shift_cnt  <= '0;
      r_cflag      <= 1'b0;
      r_reg_we     <= 1'b0;
      r_reset_req  <= 1'b0;
      r_wr_ignored <= 1'b0;
      r_reg_sel    <= '0;
      r_reg_data   <= '0;
    end else begin
      r_reg_we     <= 1'b0;
      r_reset_req  <= 1'b0;
      r_wr_ignored <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_m2) begin
            r_state <= ST_HIGH;
            r_hcnt  <= c_HCNT_W'(1);
            r_snap  <= w_bus;
          end
        end
        ST_HIGH: begin
          if (w_m2) begin
            if (r_hcnt != c_HCNT_SAT) r_hcnt <= r_hcnt + c_HCNT_W'(1);
            r_snap <= w_bus;
          end else if (r_hcnt >= c_HCNT_SAT) begin
            r_state <= ST_COMMIT;
          end else begin
            // Too short to be a real CPU cycle: drop it without touching any state
            r_state <= ST_IDLE;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          if (w_mapper_wr) begin
            r_cflag <= 1'b1;
            if (c_IGNORE && r_cflag) begin
              r_wr_ignored <= 1'b1;
            end else if (r_snap[1]) begin
              r_shreg     <= '0;
              r_shift_cnt <= '0;
              r_reset_req <= 1'b1;
            end else if (r_shift_cnt != 3'd4) begin
              r_shreg     <= w_shift_next;
              r_shift_cnt <= r_shift_cnt + 3'd1;
            end else begin
              r_reg_data  <= w_shift_next;
              r_reg_sel   <= r_snap[3:2];
              r_reg_we    <= 1'b1;
              r_shreg     <= '0;
              r_shift_cnt <= '0;
            end
          end else begin
            r_cflag <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.reg_we     = r_reg_we;
  assign bus.reg_sel    = r_reg_sel;
  assign bus.reg_data   = r_reg_data;
  assign bus.reset_req  = r_reset_req;
  assign bus.wr_ignored = r_wr_ignored;
  assign bus.shift_cnt  = r_shift_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mmc1_cpu_write_front.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mmc1_cpu_write_front
// Brief    : Directed CPU-bus cycles against two instances (filter on / off).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmc1_cpu_write_front;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] sel;
    logic [4:0] data;
  } ev_t;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_WE   = 2'd1;
  localparam logic [1:0] K_RST  = 2'd2;
  localparam logic [1:0] K_IGN  = 2'd3;

  localparam ev_t EV_NO  = '0;
  localparam ev_t EV_RST = '{kind: K_RST, sel: 2'b00, data: 5'b00000};
  localparam ev_t EV_IGN = '{kind: K_IGN, sel: 2'b00, data: 5'b00000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic m2 = 1'b0, nromsel = 1'b1, nrw = 1'b1, a14 = 1'b0, a13 = 1'b0;
  logic d7 = 1'b0, d0 = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  ev_t q_main[$];
  ev_t q_nc[$];

  mmc1_cpu_write_front_if bm();
  mmc1_cpu_write_front_if bn();

  assign bm.cpu_m2 = m2;  assign bm.ncpu_romsel = nromsel;  assign bm.ncpu_rw = nrw;
  assign bm.cpu_a14 = a14; assign bm.cpu_a13 = a13; assign bm.cpu_d7 = d7; assign bm.cpu_d0 = d0;
  assign bn.cpu_m2 = m2;  assign bn.ncpu_romsel = nromsel;  assign bn.ncpu_rw = nrw;
  assign bn.cpu_a14 = a14; assign bn.cpu_a13 = a13; assign bn.cpu_d7 = d7; assign bn.cpu_d0 = d0;

  mmc1_cpu_write_front #(.SYNC_STAGES(2), .M2_MIN_HIGH(3), .IGNORE_CONSEC(1)) dut_main (
    .clk (clk),
    .rst (rst),
    .bus (bm)
  );

  mmc1_cpu_write_front #(.SYNC_STAGES(2), .M2_MIN_HIGH(3), .IGNORE_CONSEC(0)) dut_nc (
    .clk (clk),
    .rst (rst),
    .bus (bn)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic ev_t observed(input logic we, input logic rr, input logic ig,
                                   input logic [1:0] sel, input logic [4:0] data);
    ev_t e;
    e = '0;
    if (ig)      e.kind = K_IGN;
    else if (rr) e.kind = K_RST;
    else if (we) begin
      e.kind = K_WE;
      e.sel  = sel;
      e.data = data;
    end
    return e;
  endfunction

  function automatic ev_t we_ev(input logic [1:0] sel, input logic [4:0] data);
    ev_t e;
    e.kind = K_WE;
    e.sel  = sel;
    e.data = data;
    return e;
  endfunction

  // Monitor: every pulse seen on a DUT consumes the next expected event
  always @(negedge clk) begin
    if (bm.reg_we | bm.reset_req | bm.wr_ignored) begin
      chk("main_onehot", $countones({bm.reg_we, bm.reset_req, bm.wr_ignored}), 1);
      if (q_main.size() == 0)
        chk("main_unexpected_event",
            observed(bm.reg_we, bm.reset_req, bm.wr_ignored, bm.reg_sel, bm.reg_data), EV_NO);
      else
        chk("main_event",
            observed(bm.reg_we, bm.reset_req, bm.wr_ignored, bm.reg_sel, bm.reg_data),
            q_main.pop_front());
    end
    if (bn.reg_we | bn.reset_req | bn.wr_ignored) begin
      chk("nc_onehot", $countones({bn.reg_we, bn.reset_req, bn.wr_ignored}), 1);
      if (q_nc.size() == 0)
        chk("nc_unexpected_event",
            observed(bn.reg_we, bn.reset_req, bn.wr_ignored, bn.reg_sel, bn.reg_data), EV_NO);
      else
        chk("nc_event",
            observed(bn.reg_we, bn.reset_req, bn.wr_ignored, bn.reg_sel, bn.reg_data),
            q_nc.pop_front());
    end
  end

  task automatic expect_ev(input ev_t em, input ev_t en);
    if (em.kind != K_NONE) q_main.push_back(em);
    if (en.kind != K_NONE) q_nc.push_back(en);
  endtask

  task automatic cyc(input logic rs, input logic rw, input logic x14, input logic x13,
                     input logic [7:0] dd, input int hi);
    @(negedge clk);
    nromsel = rs; nrw = rw; a14 = x14; a13 = x13; d7 = dd[7]; d0 = dd[0];
    repeat (3) @(negedge clk);
    m2 = 1'b1;
    repeat (hi) @(negedge clk);
    m2 = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wr(input logic x14, input logic x13, input logic [7:0] dd,
                    input ev_t em, input ev_t en);
    expect_ev(em, en);
    cyc(1'b0, 1'b0, x14, x13, dd, 6);
  endtask

  task automatic rd();
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 6);
  endtask

  task automatic chk_shift(input string name, input logic [2:0] em, input logic [2:0] en);
    chk({name, "_shift_main"}, bm.shift_cnt, em);
    chk({name, "_shift_nc"},   bn.shift_cnt, en);
  endtask

  task automatic drained(input string name);
    chk({name, "_pending_main"}, q_main.size(), 0);
    chk({name, "_pending_nc"},   q_nc.size(),   0);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_main"}, {bm.reg_we, bm.reset_req, bm.wr_ignored, bm.reg_sel, bm.reg_data, bm.shift_cnt}, 0);
    chk({name, "_nc"},   {bn.reg_we, bn.reset_req, bn.wr_ignored, bn.reg_sel, bn.reg_data, bn.shift_cnt}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] t1_bits;
    logic [4:0] t2_bits;
    t1_bits = 5'b01101;
    t2_bits = 5'b10010;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    rd();

    // T1: five $E000 writes, D0 = 1,0,1,1,0
    for (int i = 0; i < 5; i++) begin
      wr(1'b1, 1'b1, {7'b0, t1_bits[i]},
         (i == 4) ? we_ev(2'b11, 5'b01101) : EV_NO,
         (i == 4) ? we_ev(2'b11, 5'b01101) : EV_NO);
      rd();
      chk_shift("t1", (i == 4) ? 3'd0 : 3'(i + 1), (i == 4) ? 3'd0 : 3'(i + 1));
    end
    drained("t1");

    // T2: partial load then a D7 reset, then a full load to $A000
    for (int i = 0; i < 3; i++) begin
      wr(1'b0, 1'b1, 8'h01, EV_NO, EV_NO);
      rd();
    end
    chk_shift("t2_partial", 3'd3, 3'd3);
    wr(1'b0, 1'b1, 8'h80, EV_RST, EV_RST);
    chk_shift("t2_reset", 3'd0, 3'd0);
    rd();
    for (int i = 0; i < 5; i++) begin
      wr(1'b0, 1'b1, {7'b0, t2_bits[i]},
         (i == 4) ? we_ev(2'b01, 5'b10010) : EV_NO,
         (i == 4) ? we_ev(2'b01, 5'b10010) : EV_NO);
      rd();
    end
    chk("t2_hold_main", {bm.reg_sel, bm.reg_data}, {2'b01, 5'b10010});
    chk("t2_hold_nc",   {bn.reg_sel, bn.reg_data}, {2'b01, 5'b10010});
    drained("t2");

    // T3: RMW-style back-to-back writes
    wr(1'b0, 1'b0, 8'hFF, EV_RST, EV_RST);
    wr(1'b0, 1'b0, 8'h80, EV_IGN, EV_RST);
    rd();
    chk_shift("t3", 3'd0, 3'd0);
    drained("t3");

    // T4: short M2 pulse must not disturb shift count or the consecutive flag
    wr(1'b0, 1'b0, 8'h01, EV_NO, EV_NO);
    chk_shift("t4_first", 3'd1, 3'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 2);
    chk_shift("t4_glitch", 3'd1, 3'd1);
    wr(1'b0, 1'b0, 8'h01, EV_IGN, EV_NO);
    chk_shift("t4_after", 3'd1, 3'd2);
    drained("t4");

    rst = 1'b1;
    #1;
    chk_zero("t4_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // T5: non-mapper cycles clear the consecutive flag
    wr(1'b0, 1'b0, 8'h01, EV_NO, EV_NO);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'h01, 6);
    chk_shift("t5_6000", 3'd1, 3'd1);
    wr(1'b0, 1'b0, 8'h01, EV_NO, EV_NO);
    chk_shift("t5_accept", 3'd2, 3'd2);
    rd();
    wr(1'b0, 1'b0, 8'h01, EV_NO, EV_NO);
    chk_shift("t5_read_clears", 3'd3, 3'd3);
    rd();
    wr(1'b0, 1'b0, 8'h01, EV_NO, EV_NO);
    rd();
    chk_shift("t6_four", 3'd4, 3'd4);
    drained("t5");

    // T6: reset mid M2-high on the 5th write; M2 still high after release
    @(negedge clk);
    nromsel = 1'b0; nrw = 1'b0; a14 = 1'b1; a13 = 1'b1; d7 = 1'b0; d0 = 1'b1;
    repeat (3) @(negedge clk);
    m2 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_zero("t6_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    m2 = 1'b0;
    repeat (8) @(negedge clk);
    chk_shift("t6_after", 3'd1, 3'd1);
    chk("t6_no_we_main", {bm.reg_sel, bm.reg_data}, 0);
    rd();
    drained("t6");

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
